// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch requester, memory-stage requester,
// pipeline stall requests and the byte-wide RAM port of mem_arbiter.
//   fetch  : if_req, if_addr, if_cancel -> if_done, if_inst
//   memory : mem_req, mem_we, mem_width, mem_signed, mem_addr, mem_wdata
//            -> mem_done, mem_rdata
//   stalls : stallreq_if, stallreq_mem
//   RAM    : ram_a, ram_dout, ram_wr -> RAM; ram_din <- RAM (one-cycle latency)
// modport slave  : the arbiter
// modport master : pipeline and RAM environment around the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic              if_done;
  logic [31:0]       if_inst;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_width;
  logic              mem_signed;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic              stallreq_if;
  logic              stallreq_mem;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_cancel,
    input  mem_req, mem_we, mem_width, mem_signed, mem_addr, mem_wdata,
    input  ram_din,
    output if_done, if_inst, mem_done, mem_rdata,
    output stallreq_if, stallreq_mem,
    output ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, if_cancel,
    output mem_req, mem_we, mem_width, mem_signed, mem_addr, mem_wdata,
    output ram_din,
    input  if_done, if_inst, mem_done, mem_rdata,
    input  stallreq_if, stallreq_mem,
    input  ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM between instruction
// fetch (word reads) and the memory stage (byte/half/word loads and stores).
// Each access is split into per-byte RAM cycles; read bytes are assembled
// little-endian and sign/zero extended. The memory stage wins ties, but an
// in-flight fetch is never preempted.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : mem_arbiter_if.slave (requesters, stall requests, RAM port)
//
// state  | meaning
// IDLE   | no access in progress; accept MEM first, then IF
// IF_RD  | fetching a 4-byte instruction, abortable by if_cancel
// MEM_RD | load of 1/2/4 bytes
// MEM_WR | store of 1/2/4 bytes, one RAM write per cycle
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              sign_q, sign_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       buf_q, buf_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        req_len;
  logic [7:0]        wr_byte;
  logic [31:0]       rd_raw;
  logic [31:0]       rd_ext;

  // Address wraps silently modulo 2^ADDR_W.
  assign cur_addr = base_q + ADDR_W'(cnt_q);

  always_comb begin
    case (bus.mem_width)
      2'b00:   req_len = 3'd1;
      2'b01:   req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  always_comb begin
    case (cnt_q)
      3'd0:    wr_byte = wdata_q[7:0];
      3'd1:    wr_byte = wdata_q[15:8];
      3'd2:    wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  // The last byte is taken straight from ram_din in the completion cycle,
  // so it never passes through buf_q.
  always_comb begin
    case (len_q)
      3'd1:    rd_raw = {24'h0, bus.ram_din};
      3'd2:    rd_raw = {16'h0, bus.ram_din, buf_q[7:0]};
      default: rd_raw = {bus.ram_din, buf_q};
    endcase
    rd_ext = rd_raw;
    if (sign_q) begin
      if (len_q == 3'd1) begin
        rd_ext[31:8] = {24{rd_raw[7]}};
      end else if (len_q == 3'd2) begin
        rd_ext[31:16] = {16{rd_raw[15]}};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a       = '0;
    ram_dout    = '0;
    ram_wr      = 1'b0;

    case (state_q)
      IDLE: begin
        // Held requests are not re-accepted in the cycle their done pulses.
        if (!if_done_q && !mem_done_q) begin
          if (bus.mem_req) begin
            state_d = bus.mem_we ? MEM_WR : MEM_RD;
            base_d  = bus.mem_addr;
            len_d   = req_len;
            sign_d  = bus.mem_signed;
            wdata_d = bus.mem_wdata;
            cnt_d   = '0;
          end else if (bus.if_req && !bus.if_cancel) begin
            state_d = IF_RD;
            base_d  = bus.if_addr;
            len_d   = 3'd4;
            sign_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      IF_RD, MEM_RD: begin
        if (cnt_q < len_q) begin
          ram_a = cur_addr;
        end
        if (state_q == IF_RD && bus.if_cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == len_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == IF_RD) begin
            if_done_d = 1'b1;
            if_inst_d = rd_ext;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = rd_ext;
          end
        end else begin
          // ram_din now holds the byte addressed when cnt was one lower.
          case (cnt_q)
            3'd1:    buf_d[7:0]   = bus.ram_din;
            3'd2:    buf_d[15:8]  = bus.ram_din;
            3'd3:    buf_d[23:16] = bus.ram_din;
            default: buf_d        = buf_q;
          endcase
          cnt_d = cnt_q + 3'd1;
        end
      end

      MEM_WR: begin
        ram_a    = cur_addr;
        ram_dout = wr_byte;
        ram_wr   = 1'b1;
        if (cnt_q == len_q - 3'd1) begin
          state_d     = IDLE;
          cnt_d       = '0;
          mem_done_d  = 1'b1;
          mem_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      sign_q      <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.if_done      = if_done_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.ram_a        = ram_a;
  assign bus.ram_dout     = ram_dout;
  assign bus.ram_wr       = ram_wr;
  assign bus.stallreq_if  = bus.if_req & ~if_done_q & ~bus.if_cancel;
  assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int K_NONE  = 0;
  localparam int K_FETCH = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- RAM environment (one-cycle read latency) ----------------
  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  bit ram_loaded = 1'b0;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0:       return 8'h13;
      1:       return 8'h05;
      2:       return 8'h00;
      3:       return 8'h00;
      'h20:    return 8'h80;
      'h21:    return 8'h81;
      default: return 8'((i * 37 + 11));
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
      ram_loaded <= 1'b1;
    end else if (bus.ram_wr) begin
      ram[bus.ram_a[7:0]] <= bus.ram_dout;
    end
    bus.ram_din <= ram[bus.ram_a[7:0]];
  end

  // ---------------- transaction-level reference model ----------------
  int          m_kind = K_NONE;
  int          m_c, m_n, m_done_at = -1, free_at = 0, k;
  logic [31:0] m_addr, m_wdata, m_val;
  logic [31:0] exp_if_inst = '0, exp_mem_rdata = '0;
  logic        e_if_done, e_mem_done, e_wr, chk_a, chk_d;
  logic [31:0] e_a;
  logic [7:0]  e_dout;

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v;
    logic [31:0] ai;
    v = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v  = v | (32'(ref_mem[ai[7:0]]) << (8 * i));
    end
    if (n == 1 && sgn && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && sgn && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_if_done",   {31'h0, bus.if_done},  32'h0);
      chk("rst_mem_done",  {31'h0, bus.mem_done}, 32'h0);
      chk("rst_if_inst",   bus.if_inst,           32'h0);
      chk("rst_mem_rdata", bus.mem_rdata,         32'h0);
      chk("rst_ram_a",     bus.ram_a,             32'h0);
      chk("rst_ram_dout",  {24'h0, bus.ram_dout}, 32'h0);
      chk("rst_ram_wr",    {31'h0, bus.ram_wr},   32'h0);
      m_kind        = K_NONE;
      m_done_at     = -1;
      free_at       = 0;
      exp_if_inst   = '0;
      exp_mem_rdata = '0;
    end else begin
      e_if_done  = (m_kind == K_FETCH) && (cyc == m_done_at);
      e_mem_done = (m_kind == K_LOAD || m_kind == K_STORE) && (cyc == m_done_at);
      if (e_if_done)  exp_if_inst = m_val;
      if (e_mem_done) exp_mem_rdata = (m_kind == K_STORE) ? 32'h0 : m_val;
      e_wr = 1'b0; e_a = '0; e_dout = '0; chk_a = 1'b1; chk_d = 1'b1;
      if (m_kind != K_NONE && cyc > m_c && cyc < m_done_at) begin
        k = cyc - m_c;
        if (m_kind == K_STORE) begin
          e_wr   = 1'b1;
          e_a    = m_addr + 32'(k - 1);
          e_dout = m_wdata[8*(k-1) +: 8];
          ref_mem[e_a[7:0]] = e_dout;
        end else begin
          chk_d = 1'b0;
          if (k <= m_n) e_a = m_addr + 32'(k - 1);
          else chk_a = 1'b0;
        end
      end
      chk("if_done",   {31'h0, bus.if_done},  {31'h0, e_if_done});
      chk("mem_done",  {31'h0, bus.mem_done}, {31'h0, e_mem_done});
      chk("if_inst",   bus.if_inst,   exp_if_inst);
      chk("mem_rdata", bus.mem_rdata, exp_mem_rdata);
      chk("ram_wr",    {31'h0, bus.ram_wr}, {31'h0, e_wr});
      if (chk_a) chk("ram_a", bus.ram_a, e_a);
      if (chk_d) chk("ram_dout", {24'h0, bus.ram_dout}, {24'h0, e_dout});
      chk("stallreq_if",  {31'h0, bus.stallreq_if},
          {31'h0, bus.if_req & ~e_if_done & ~bus.if_cancel});
      chk("stallreq_mem", {31'h0, bus.stallreq_mem}, {31'h0, bus.mem_req & ~e_mem_done});

      if (m_kind == K_FETCH && cyc > m_c && cyc < m_done_at && bus.if_cancel) begin
        m_kind  = K_NONE;
        free_at = cyc + 1;
      end
      if ((m_kind == K_NONE || cyc >= m_done_at) && cyc >= free_at) begin
        if (bus.mem_req) begin
          m_n       = (bus.mem_width == 2'b00) ? 1 : (bus.mem_width == 2'b01) ? 2 : 4;
          m_kind    = bus.mem_we ? K_STORE : K_LOAD;
          m_c       = cyc;
          m_addr    = bus.mem_addr;
          m_wdata   = bus.mem_wdata;
          m_done_at = bus.mem_we ? cyc + m_n + 1 : cyc + m_n + 2;
          free_at   = m_done_at + 1;
          if (!bus.mem_we) m_val = model_read(bus.mem_addr, m_n, bus.mem_signed);
        end else if (bus.if_req && !bus.if_cancel) begin
          m_n       = 4;
          m_kind    = K_FETCH;
          m_c       = cyc;
          m_addr    = bus.if_addr;
          m_done_at = cyc + 6;
          free_at   = m_done_at + 1;
          m_val     = model_read(bus.if_addr, 4, 1'b0);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  int          t0, st_if_cnt, st_mem_cnt, wr_cnt, dc;
  logic [31:0] a_at3, v;

  task automatic clr_cnt();
    st_if_cnt = 0; st_mem_cnt = 0; wr_cnt = 0; a_at3 = 'x;
  endtask

  task automatic wait_done(input bit for_if, output int d, output logic [31:0] val);
    d = -1; val = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.stallreq_if)  st_if_cnt++;
      if (bus.stallreq_mem) st_mem_cnt++;
      if (bus.ram_wr)       wr_cnt++;
      if (cyc - t0 == 3)    a_at3 = bus.ram_a;
      if (for_if ? bus.if_done : bus.mem_done) begin
        d   = cyc - t0;
        val = for_if ? bus.if_inst : bus.mem_rdata;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, output int d, output logic [31:0] val);
    @(posedge clk); #1;
    clr_cnt(); t0 = cyc;
    bus.if_addr = a; bus.if_req = 1'b1;
    wait_done(1'b1, d, val);
    bus.if_req = 1'b0;
  endtask

  task automatic do_mem(input bit we, input logic [1:0] w, input bit sgn,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int d, output logic [31:0] val);
    @(posedge clk); #1;
    clr_cnt(); t0 = cyc;
    bus.mem_we = we; bus.mem_width = w; bus.mem_signed = sgn;
    bus.mem_addr = a; bus.mem_wdata = wd; bus.mem_req = 1'b1;
    wait_done(1'b0, d, val);
    bus.mem_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 5) == 0) a[31:8] = 24'hFF_FFFF;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cancel_prev;
    bus.if_req = 0; bus.if_addr = '0; bus.if_cancel = 0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_width = '0; bus.mem_signed = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    do_fetch(32'h100, dc, v);
    chk("fetch_done_cycle", 32'(dc), 32'd6);
    chk("fetch_inst", v, 32'h0000_0513);
    chk("fetch_stall_cycles", 32'(st_if_cnt), 32'd6);

    do_mem(1'b0, 2'b00, 1'b1, 32'h20, '0, dc, v);
    chk("lb_done_cycle", 32'(dc), 32'd3);
    chk("lb_data", v, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(st_mem_cnt), 32'd3);
    do_mem(1'b0, 2'b00, 1'b0, 32'h20, '0, dc, v);
    chk("lbu_data", v, 32'h0000_0080);
    do_mem(1'b0, 2'b01, 1'b1, 32'h20, '0, dc, v);
    chk("lh_done_cycle", 32'(dc), 32'd4);
    chk("lh_data", v, 32'hFFFF_8180);
    do_mem(1'b0, 2'b01, 1'b0, 32'h20, '0, dc, v);
    chk("lhu_data", v, 32'h0000_8180);

    do_mem(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, dc, v);
    chk("sw_done_cycle", 32'(dc), 32'd5);
    chk("sw_rdata_zero", v, 32'h0);
    chk("sw_wr_cycles", 32'(wr_cnt), 32'd4);
    chk("sw_ram_bytes", {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]}, 32'hDEAD_BEEF);
    do_mem(1'b0, 2'b10, 1'b0, 32'h40, '0, dc, v);
    chk("lw_done_cycle", 32'(dc), 32'd6);
    chk("lw_data", v, 32'hDEAD_BEEF);

    do_fetch(32'hFFFF_FFFE, dc, v);
    chk("wrap_addr", a_at3, 32'h0);
    chk("wrap_inst", v, 32'h0513_E6C1);

    // Priority: both requests rise together.
    @(posedge clk); #1;
    clr_cnt(); t0 = cyc;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    bus.mem_we = 1'b0; bus.mem_width = 2'b10; bus.mem_addr = 32'h40; bus.mem_req = 1'b1;
    wait_done(1'b0, dc, v);
    bus.mem_req = 1'b0;
    chk("pri_mem_done_cycle", 32'(dc), 32'd6);
    chk("pri_mem_data", v, 32'hDEAD_BEEF);
    wait_done(1'b1, dc, v);
    bus.if_req = 1'b0;
    chk("pri_if_done_cycle", 32'(dc), 32'd13);
    chk("pri_if_inst", v, 32'h0000_0513);
    chk("pri_stall_if_cycles", 32'(st_if_cnt), 32'd13);

    // Cancel an in-flight fetch with a load waiting behind it.
    begin
      int seen_ifd, seen_wr, md;
      seen_ifd = 0; seen_wr = 0; md = -1;
      @(posedge clk); #1;
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      for (int kk = 0; kk < 14; kk++) begin
        if (kk > 0) begin @(posedge clk); #1; end
        if (kk == 2) begin
          bus.mem_we = 1'b0; bus.mem_width = 2'b10; bus.mem_addr = 32'h20; bus.mem_req = 1'b1;
        end
        if (kk == 3) bus.if_cancel = 1'b1;
        if (kk == 4) begin bus.if_cancel = 1'b0; bus.if_req = 1'b0; end
        if (md >= 0 && kk == md + 1) bus.mem_req = 1'b0;
        @(negedge clk);
        if (bus.if_done) seen_ifd++;
        if (bus.ram_wr)  seen_wr++;
        if (bus.mem_done && md < 0) md = kk;
      end
      chk("cancel_no_if_done", 32'(seen_ifd), 32'd0);
      chk("cancel_no_ram_wr", 32'(seen_wr), 32'd0);
      chk("cancel_mem_done_cycle", 32'(md), 32'd10);
      chk("cancel_if_inst_kept", bus.if_inst, 32'h0000_0513);
    end

    // Reset in the middle of a store.
    @(posedge clk); #1;
    bus.mem_we = 1'b1; bus.mem_width = 2'b10; bus.mem_addr = 32'hC0;
    bus.mem_wdata = 32'h1122_3344; bus.mem_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rstmid_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
    chk("rstmid_mem_rdata", bus.mem_rdata, 32'h0);
    chk("rstmid_if_inst", bus.if_inst, 32'h0);
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_mem(1'b0, 2'b10, 1'b0, 32'h40, '0, dc, v);
    chk("post_rst_lw_cycle", 32'(dc), 32'd6);
    chk("post_rst_lw_data", v, 32'hDEAD_BEEF);

    // Randomized traffic checked by the model every cycle.
    cancel_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!bus.mem_req || bus.mem_done) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.mem_we     = 1'($urandom_range(0, 1));
          bus.mem_width  = 2'($urandom_range(0, 3));
          bus.mem_signed = 1'($urandom_range(0, 1));
          bus.mem_addr   = rand_addr();
          bus.mem_wdata  = $urandom;
          bus.mem_req    = 1'b1;
        end else begin
          bus.mem_req = 1'b0;
        end
      end
      if (!bus.if_req || bus.if_done || cancel_prev) begin
        bus.if_cancel = 1'b0;
        cancel_prev   = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
          bus.if_addr = rand_addr();
          bus.if_req  = 1'b1;
        end else begin
          bus.if_req = 1'b0;
        end
      end else begin
        cancel_prev   = ($urandom_range(0, 11) == 0);
        bus.if_cancel = cancel_prev;
      end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_cancel = 1'b0; bus.mem_req = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide synchronous RAM port between the instruction-fetch stage (word reads) and the memory stage (byte/half/word loads and stores). Serialises each access into per-byte RAM cycles, assembles little-endian read data with sign/zero extension, and raises stall requests toward the pipeline controller while a requester waits. MEM has priority over IF. An in-flight fetch is aborted when the pipeline flushes it.

## Interface
- ADDR_W, 32, address width of both requesters and the RAM port.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- if_req  in  1  fetch request; held with if_addr until if_done or if_cancel.
- if_addr  in  ADDR_W  fetch address.
- if_cancel  in  1  abort the pending or in-flight fetch (branch flush).
- if_done  out  1  one-cycle pulse, if_inst valid.
- if_inst  out  32  fetched instruction.
- mem_req  in  1  load/store request; held with operands until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_width  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- mem_signed  in  1  load sign-extends when 1.
- mem_addr  in  ADDR_W  access base address.
- mem_wdata  in  32  store data; low bytes used.
- mem_done  out  1  one-cycle pulse, mem_rdata valid for loads.
- mem_rdata  out  32  extended load data; 0 after stores.
- stallreq_if  out  1  = if_req & ~if_done & ~if_cancel.
- stallreq_mem  out  1  = mem_req & ~mem_done.
- ram_a  out  ADDR_W  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_wr  out  1  RAM write enable.
- ram_din  in  8  RAM read byte; byte for address driven in cycle t appears in cycle t+1.

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter cnt 0..4. Transaction length N = 1/2/4 from width (IF always 4).
- IDLE: if mem_req -> MEM_WR or MEM_RD; else if if_req & ~if_cancel -> IF_RD. Latch address, N, sign, write data; cnt <= 0. Requests are ignored in any cycle where if_done or mem_done is high.
- Read states: while cnt < N drive ram_a = base + cnt, ram_wr = 0. In the cycle with cnt = k ≥ 1, capture ram_din as byte k-1. When cnt = N, capture the last byte, assemble the little-endian value, and sign/zero-extend from 8/16 bits. Register the result with done = 1. Return to IDLE.
- MEM_WR: for cnt = 0..N-1 drive ram_a = base + cnt, ram_dout = wdata[8cnt+7:8cnt], ram_wr = 1. After cnt = N-1, register mem_done = 1 and mem_rdata = 0. Return to IDLE.
- Addresses increment modulo 2^ADDR_W; wrap is silent.
- No preemption: an arriving mem_req waits for an in-flight fetch to finish. Its stall request stays high meanwhile.
- if_cancel in IF_RD: next state IDLE, no if_done, partial bytes discarded, if_inst unchanged. if_cancel has no effect on MEM states.
- Outside write cycles ram_wr = 0. In IDLE ram_a = 0 and ram_dout = 0.
- Reset (asynchronous): state IDLE, cnt 0, if_done = mem_done = 0, if_inst = mem_rdata = 0, ram_a = ram_dout = 0, ram_wr = 0. Reset takes effect immediately, including mid-transaction; a partial store may remain in RAM.

## Timing
- Request first seen in IDLE in cycle 0 -> first RAM address in cycle 1.
- Read of N bytes: done high in cycle N+2 (word fetch/load: cycle 6; byte load: cycle 3).
- Write of N bytes: ram_wr high cycles 1..N, done high in cycle N+1 (sw: cycle 5).
- done is exactly one cycle. The state in the done cycle is IDLE, but new acceptance happens no earlier than the cycle after done.
- Back-to-back word fetches: 7-cycle period.
- Stall outputs are combinational from inputs and the done registers. They fall in the done cycle.

## Test plan
- Fetch: RAM[0x100..0x103] = 13 05 00 00, if_req at 0x100 -> ram_a 0x100..0x103 in cycles 1-4, if_done in cycle 6, if_inst = 0x00000513, stallreq_if high cycles 0-5.
- Loads: RAM[0x20] = 0x80, 0x81: lb -> 0xFFFFFF80 in cycle 3; lbu -> 0x00000080; lh -> 0xFFFF8180 in cycle 4; lhu -> 0x00008180.
- Store: sw 0xDEADBEEF at 0x40 -> ram_wr cycles 1-4 with bytes EF BE AD DE at 0x40..0x43, mem_done in cycle 5. A following lw 0x40 returns 0xDEADBEEF.
- Priority: if_req and mem_req (lw) both rise in cycle 0 -> MEM served first, mem_done in cycle 6. Fetch accepted in cycle 7, if_done in cycle 13. stallreq_if high throughout cycles 0-12.
- Cancel: fetch in flight, if_cancel in cycle 3 -> IDLE in cycle 4, no if_done, ram_wr never asserted. A pending mem_req is accepted in cycle 4.
- Reset mid-store: rst low during cycle 2 of sw -> ram_wr drops immediately, all outputs 0, state IDLE. A new lw after rst rises completes normally.
